instr_mem_banked: RTL and testbench
===================================

Name: instr_mem_banked

Overview:
- Parametrised, writable successor to the fixed program ROM.
- Holds NUM_BANKS independent program images of DEPTH words each, INSTR_WIDTH bits wide.
- Programs are loaded through a write port after reset. The core then fetches through a registered, pipelined request/valid port.
- Unwritten or out-of-range locations return NOP_WORD and raise a fault flag, so the core never executes undefined contents.

Parameters:
- INSTR_WIDTH, 9, instruction word width.
- ADDR_WIDTH, 8, fetch/load address width.
- DEPTH, 256, implemented words per bank (DEPTH <= 2**ADDR_WIDTH).
- NUM_BANKS, 2, number of program images.
- BANK_WIDTH, 1, bank select width (clog2(NUM_BANKS), min 1).
- NOP_WORD, 9'b0000_00_000, word returned on fault and at reset.

Ports:
- clock  in  1  system clock, all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- load_we  in  1  write strobe, honoured only in LOADING.
- load_bank  in  BANK_WIDTH  target bank.
- load_addr  in  ADDR_WIDTH  target word.
- load_data  in  INSTR_WIDTH  word to write.
- load_done  in  1  pulse: LOADING -> RUN.
- reload  in  1  pulse: RUN -> LOADING.
- load_err  out  1  one-cycle pulse: write rejected.
- busy  out  1  high while in LOADING.
- fetch_req  in  1  fetch request, one per cycle max.
- fetch_bank  in  BANK_WIDTH  bank for this request.
- fetch_addr  in  ADDR_WIDTH  word address.
- fetch_valid  out  1  instruction valid, one cycle after accepted request.
- instruction  out  INSTR_WIDTH  fetched word.
- fetch_fault  out  1  qualifies fetch_valid: NOP_WORD substituted.

Behaviour:
- FSM states:
  - LOADING is the reset state.
  - LOADING -> RUN on load_done.
  - RUN -> LOADING on reload.
  - load_done in RUN is ignored. reload in LOADING is ignored.
- Reset (async assert, sync deassert handled externally):
  - state = LOADING, busy = 1.
  - fetch_valid = 0, fetch_fault = 0, load_err = 0, instruction = NOP_WORD.
  - All per-word written bits are cleared. The data array itself is not reset.
- Load:
  - In LOADING, load_we with load_addr < DEPTH and load_bank < NUM_BANKS writes mem[bank][addr] and sets that word's written bit at the clock edge.
  - Any other load_we in LOADING: no write; load_err = 1 the next cycle.
  - load_we in RUN: no write; load_err = 1.
  - Rewriting a word overwrites it; the last write wins.
- Load boundary cases:
  - load_we and load_done in the same cycle: the write is accepted, then the FSM enters RUN.
  - reload does not clear written bits, so RUN -> LOADING allows patching individual words. Only reset clears them.
- Fetch:
  - A request is accepted only in RUN. In LOADING, fetch_req is ignored: fetch_valid stays 0 and no fault is raised.
  - Accepted request at edge N -> at edge N+1, fetch_valid = 1.
  - The address is in range and written: instruction = stored word, fetch_fault = 0.
  - Otherwise: instruction = NOP_WORD, fetch_fault = 1. "Otherwise" covers addr >= DEPTH, bank >= NUM_BANKS, or written bit clear.
  - Fully pipelined: back-to-back requests give back-to-back valids, throughput 1/cycle, latency 1.
  - With no request, fetch_valid = 0 and instruction holds its last value.
- Fetch boundary cases:
  - Bank and address are sampled with the request; changes afterwards do not affect the in-flight result.
  - fetch_req and reload in the same cycle: the request is served (valid next cycle), then the FSM is in LOADING.
  - A load write and a fetch cannot coincide, because the states are exclusive.
- Addressing:
  - Address arithmetic is unsigned.
  - No wrap-around: an address beyond DEPTH faults rather than aliasing.

Test Plan:
- Reset, then fetch_req addr 0 while busy -> fetch_valid stays 0, busy = 1. load_err = 0.
- Load bank0 addr0 = 9'h141 and addr1 = 9'h031, pulse load_done, fetch addr0 then addr1 on consecutive cycles -> valid on two consecutive cycles with 9'h141 then 9'h031. fetch_fault = 0 on both.
- In RUN, fetch bank1 addr0 (never written) -> instruction = 9'h000, fetch_fault = 1.
- With DEPTH=200, load_we addr 200 -> load_err pulse, no write. After RUN, fetch addr 200 -> NOP_WORD and fault.
- In RUN, load_we -> load_err = 1 and contents unchanged. Then reload and write bank0 addr0 = 9'h0A8, load_done, fetch addr0 -> 9'h0A8. addr1 still returns 9'h031.
- Assert reset_n low mid-stream with a valid pending -> fetch_valid = 0 and busy = 1 immediately. After reset, fetch of a previously written word (after load_done) -> fault = 1.

Source files
------------

// File: rtl/instr_mem_banked_if.sv
// Load and fetch bus of the banked instruction memory.
// The master side is the loader/core; the slave side is the memory.
interface instr_mem_banked_if #(
    parameter int INSTR_WIDTH = 9,
    parameter int ADDR_WIDTH  = 8,
    parameter int BANK_WIDTH  = 1
);
    logic                   load_we;
    logic [BANK_WIDTH-1:0]  load_bank;
    logic [ADDR_WIDTH-1:0]  load_addr;
    logic [INSTR_WIDTH-1:0] load_data;
    logic                   load_done;
    logic                   reload;
    logic                   load_err;
    logic                   busy;
    logic                   fetch_req;
    logic [BANK_WIDTH-1:0]  fetch_bank;
    logic [ADDR_WIDTH-1:0]  fetch_addr;
    logic                   fetch_valid;
    logic [INSTR_WIDTH-1:0] instruction;
    logic                   fetch_fault;

    modport master (
        output load_we, load_bank, load_addr, load_data, load_done, reload,
        output fetch_req, fetch_bank, fetch_addr,
        input  load_err, busy, fetch_valid, instruction, fetch_fault
    );

    modport slave (
        input  load_we, load_bank, load_addr, load_data, load_done, reload,
        input  fetch_req, fetch_bank, fetch_addr,
        output load_err, busy, fetch_valid, instruction, fetch_fault
    );
endinterface

// File: rtl/instr_mem_banked.sv
// Writable multi-bank program memory with a load phase and a pipelined fetch port.
// Unwritten or out-of-range words fetch as NOP_WORD with fetch_fault raised.
module instr_mem_banked #(
    parameter int INSTR_WIDTH = 9,
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH       = 256,
    parameter int NUM_BANKS   = 2,
    parameter int BANK_WIDTH  = 1,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD = 9'b0_0000_0000
) (
    input  logic               clock,
    input  logic               reset_n,
    instr_mem_banked_if.slave  bus
);
    localparam int WORD_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BANK_IDX_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    typedef enum logic [0:0] {
        LOADING = 1'b0,
        RUN     = 1'b1
    } state_t;

    state_t                 state_r;
    logic [INSTR_WIDTH-1:0] mem_r     [NUM_BANKS][DEPTH];
    logic [DEPTH-1:0]       written_r [NUM_BANKS];

    logic                   load_ok_s;
    logic [BANK_IDX_W-1:0]  load_bank_idx_s;
    logic [WORD_IDX_W-1:0]  load_word_idx_s;
    logic                   fetch_acc_s;
    logic                   fetch_hit_s;
    logic [BANK_IDX_W-1:0]  fetch_bank_idx_s;
    logic [WORD_IDX_W-1:0]  fetch_word_idx_s;
    logic [INSTR_WIDTH-1:0] fetch_word_s;

    function automatic logic in_range(input logic [BANK_WIDTH-1:0] bank,
                                      input logic [ADDR_WIDTH-1:0] addr);
        return (32'(bank) < 32'(NUM_BANKS)) && (32'(addr) < 32'(DEPTH));
    endfunction

    // Load qualification: writes land only in LOADING and only in range.
    always_comb begin
        load_ok_s       = 1'b0;
        load_bank_idx_s = '0;
        load_word_idx_s = '0;
        if ((state_r == LOADING) && bus.load_we && in_range(bus.load_bank, bus.load_addr)) begin
            load_ok_s       = 1'b1;
            load_bank_idx_s = bus.load_bank[BANK_IDX_W-1:0];
            load_word_idx_s = bus.load_addr[WORD_IDX_W-1:0];
        end else begin
            load_ok_s       = 1'b0;
        end
    end

    // Fetch lookup; indices are forced to zero when out of range so no aliasing read occurs.
    always_comb begin
        fetch_acc_s      = bus.fetch_req && (state_r == RUN);
        fetch_hit_s      = 1'b0;
        fetch_bank_idx_s = '0;
        fetch_word_idx_s = '0;
        fetch_word_s     = NOP_WORD;
        if (in_range(bus.fetch_bank, bus.fetch_addr)) begin
            fetch_bank_idx_s = bus.fetch_bank[BANK_IDX_W-1:0];
            fetch_word_idx_s = bus.fetch_addr[WORD_IDX_W-1:0];
            fetch_hit_s      = written_r[fetch_bank_idx_s][fetch_word_idx_s];
            if (fetch_hit_s) begin
                fetch_word_s = mem_r[fetch_bank_idx_s][fetch_word_idx_s];
            end else begin
                fetch_word_s = NOP_WORD;
            end
        end else begin
            fetch_hit_s  = 1'b0;
            fetch_word_s = NOP_WORD;
        end
    end

    // Program storage is deliberately unreset; the written bits decide what is trustworthy.
    always_ff @(posedge clock) begin
        if (load_ok_s) begin
            mem_r[load_bank_idx_s][load_word_idx_s] <= bus.load_data;
        end
    end

    // Mode FSM, written-bit tracking and all registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= LOADING;
            bus.busy        <= 1'b1;
            bus.load_err    <= 1'b0;
            bus.fetch_valid <= 1'b0;
            bus.fetch_fault <= 1'b0;
            bus.instruction <= NOP_WORD;
            for (int b = 0; b < NUM_BANKS; b++) begin
                written_r[b] <= '0;
            end
        end else begin
            bus.load_err    <= bus.load_we && !load_ok_s;
            bus.fetch_valid <= fetch_acc_s;
            if (fetch_acc_s) begin
                bus.instruction <= fetch_word_s;
                bus.fetch_fault <= !fetch_hit_s;
            end else begin
                bus.fetch_fault <= 1'b0;
            end
            if (load_ok_s) begin
                written_r[load_bank_idx_s][load_word_idx_s] <= 1'b1;
            end
            case (state_r)
                LOADING: begin
                    if (bus.load_done) begin
                        state_r  <= RUN;
                        bus.busy <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.reload) begin
                        state_r  <= LOADING;
                        bus.busy <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= LOADING;
                    bus.busy <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_mem_banked.sv
// Self-checking bench for instr_mem_banked: a reference model pushes expected
// fetch results into a queue, and a monitor pops them when fetch_valid rises.
module tb_instr_mem_banked;
    localparam int IW    = 9;
    localparam int AW    = 8;
    localparam int DEPTH = 200;
    localparam int NB    = 2;
    localparam int BW    = 1;
    localparam logic [IW-1:0] NOP = 9'h000;

    typedef struct {
        int          due;
        logic        fault;
        logic [IW-1:0] instr;
    } exp_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    instr_mem_banked_if #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW), .BANK_WIDTH(BW)) bus ();

    instr_mem_banked #(
        .INSTR_WIDTH(IW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
        .NUM_BANKS(NB), .BANK_WIDTH(BW), .NOP_WORD(NOP)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    int            err_due  = -1;
    bit            model_run = 1'b0;
    logic [IW-1:0] model_mem [NB][256];
    bit            model_wr  [NB][256];
    exp_t          q[$];
    exp_t          mon_e;
    logic          mon_exp_valid;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < 256; a++)
                model_wr[b][a] = 1'b0;
        model_run = 1'b0;
        err_due   = -1;
        q.delete();
    endtask

    // One clock of stimulus, driven on the falling edge, with the model updated alongside.
    task automatic cycle(input bit we, input int lb, input int la, input int ld,
                         input bit done, input bit rel, input bit req, input int fb, input int fa);
        exp_t e;
        bit   hit;
        @(negedge clock);
        bus.load_we    = we;
        bus.load_bank  = BW'(lb);
        bus.load_addr  = AW'(la);
        bus.load_data  = IW'(ld);
        bus.load_done  = done;
        bus.reload     = rel;
        bus.fetch_req  = req;
        bus.fetch_bank = BW'(fb);
        bus.fetch_addr = AW'(fa);
        if (req && model_run) begin
            hit     = (fb < NB) && (fa < DEPTH) && model_wr[fb][fa];
            e.due   = cyc + 1;
            e.fault = !hit;
            e.instr = hit ? model_mem[fb][fa] : NOP;
            q.push_back(e);
        end
        if (we) begin
            if (!model_run && (lb < NB) && (la < DEPTH)) begin
                model_mem[lb][la] = IW'(ld);
                model_wr[lb][la]  = 1'b1;
            end else begin
                err_due = cyc + 1;
            end
        end
        if (!model_run && done) model_run = 1'b1;
        else if (model_run && rel) model_run = 1'b0;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic load(input int b, input int a, input int d);
        cycle(1, b, a, d, 0, 0, 0, 0, 0);
    endtask
    task automatic fetch(input int b, input int a);
        cycle(0, 0, 0, 0, 0, 0, 1, b, a);
    endtask

    // Per-cycle output monitor, sampled just after the rising edge.
    always @(posedge clock) begin
        cyc++;
        #1;
        mon_exp_valid = (q.size() > 0) && (q[0].due == cyc);
        check_eq("fetch_valid", bus.fetch_valid, mon_exp_valid);
        if (mon_exp_valid) begin
            mon_e = q.pop_front();
            check_eq("instruction", bus.instruction, mon_e.instr);
            check_eq("fetch_fault", bus.fetch_fault, mon_e.fault);
        end
        check_eq("load_err", bus.load_err, err_due == cyc);
    end

    initial begin
        bus.load_we = 1'b0; bus.load_bank = '0; bus.load_addr = '0; bus.load_data = '0;
        bus.load_done = 1'b0; bus.reload = 1'b0;
        bus.fetch_req = 1'b0; bus.fetch_bank = '0; bus.fetch_addr = '0;
        model_reset();

        repeat (2) @(negedge clock);
        check_eq("rst_busy",  bus.busy, 1);
        check_eq("rst_valid", bus.fetch_valid, 0);
        check_eq("rst_fault", bus.fetch_fault, 0);
        check_eq("rst_err",   bus.load_err, 0);
        check_eq("rst_instr", bus.instruction, NOP);
        reset_n = 1'b1;

        // Fetch and reload are ignored while loading.
        fetch(0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle();
        check_eq("busy_loading", bus.busy, 1);

        load(0, 0, 9'h141);
        load(0, 1, 9'h031);
        load(0, 200, 9'h1FF);
        load(1, 255, 9'h1FF);
        cycle(1, 1, 5, 9'h155, 1, 0, 0, 0, 0);
        idle();
        check_eq("busy_run", bus.busy, 0);

        fetch(0, 0);
        fetch(0, 1);
        fetch(1, 0);
        fetch(0, 200);
        fetch(1, 5);
        fetch(0, 199);
        fetch(0, 255);
        idle();

        // Writes in RUN are rejected; load_done in RUN changes nothing.
        load(0, 0, 9'h1FF);
        cycle(0, 0, 0, 0, 1, 0, 1, 0, 0);
        idle();
        check_eq("busy_done_in_run", bus.busy, 0);

        // Reload coinciding with a fetch: the fetch is served, then patching begins.
        cycle(0, 0, 0, 0, 0, 1, 1, 0, 1);
        fetch(0, 0);
        check_eq("busy_reload", bus.busy, 1);
        load(0, 0, 9'h0A8);
        load(0, 2, 9'h0AA);
        load(0, 2, 9'h0BB);
        cycle(0, 0, 0, 0, 1, 0, 0, 0, 0);
        fetch(0, 0);
        fetch(0, 1);
        fetch(0, 2);
        fetch(1, 5);

        for (int i = 0; i < 24; i++) begin
            fetch($urandom_range(0, 1), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                                                    : $urandom_range(0, 5));
        end
        idle();

        // Asynchronous reset with a valid on the bus.
        fetch(0, 0);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_eq("mid_rst_valid", bus.fetch_valid, 0);
        check_eq("mid_rst_busy",  bus.busy, 1);
        bus.fetch_req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        cycle(0, 0, 0, 0, 1, 0, 0, 0, 0);
        fetch(0, 0);
        fetch(0, 1);
        idle();
        idle();
        idle();
        check_eq("drain", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
